// File: rtl/led_pkg.sv
// led_pkg: mode and state encodings shared by the LED sequencer files.
package led_pkg;
  localparam logic [1:0] MODE_SOLID = 2'b00;
  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_CHASE = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: animation prescaler emitting a one-cycle tick every TICK_DIV cycles while run is high.
module led_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = run && !restart && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (reset || restart || !run || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: timing-phase LED animation (solid/blink/chase) followed by a result bar hold.
module led_sequencer
  import led_pkg::*;
#(
  parameter int LED_COUNT  = 10,
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic [1:0]                         mode,
  input  logic [$clog2(LED_COUNT+1)-1:0]     level,
  output logic [LED_COUNT-1:0]               led,
  output logic                               busy
);
  localparam int LW = $clog2(LED_COUNT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 2);
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [LW-1:0] level_q;
  logic [LED_COUNT-1:0] pat, bar;
  logic [HW-1:0] hcnt;
  logic tick, run, restart, go_active, go_hold, stop_active, hold_done;
  // Stop outranks start everywhere; start is ignored only while already ACTIVE.
  always_comb begin
    stop_active = stop && state == ST_ACTIVE;
    go_active = start && !stop && state != ST_ACTIVE;
    go_hold = stop_active && HOLD_TICKS > 0;
    hold_done = state == ST_HOLD && tick && 32'(hcnt) == HOLD_TICKS - 1;
    run = state != ST_IDLE;
    restart = go_active || go_hold;
    state_nx = go_active ? ST_ACTIVE :
               stop_active ? (go_hold ? ST_HOLD : ST_IDLE) :
               hold_done ? ST_IDLE : state;
  end
  always_comb begin
    bar = '0;
    for (int i = 0; i < LED_COUNT; i++) bar[i] = level_q > LW'(i);
  end
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .run(run),
    .restart(restart),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  // led and busy are a second register stage, so both follow the state by one cycle.
  always_ff @(posedge clk)
    if (reset) begin
      mode_q <= MODE_SOLID;
      level_q <= '0;
      pat <= '0;
      hcnt <= '0;
      led <= '0;
      busy <= 1'b0;
    end else begin
      led <= state == ST_ACTIVE ? pat : state == ST_HOLD ? bar : '0;
      busy <= state != ST_IDLE;
      if (go_active) begin
        mode_q <= mode;
        pat <= mode == MODE_CHASE ? LED_COUNT'(1) : '1;
      end else if (state == ST_ACTIVE && tick)
        pat <= mode_q == MODE_BLINK ? ~pat :
               mode_q == MODE_CHASE ? {pat[LED_COUNT-2:0], pat[LED_COUNT-1]} : pat;
      if (stop_active) level_q <= level;
      hcnt <= go_hold ? '0 : (state == ST_HOLD && tick) ? hcnt + 1'b1 : hcnt;
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer with LED_COUNT=10, TICK_DIV=4, HOLD_TICKS=2.
module tb_led_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] level = 4'd0;
  logic [9:0] led;
  logic busy;
  typedef struct {
    logic [9:0] led;
    logic busy;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(.LED_COUNT(10), .TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .mode(mode),
    .level(level),
    .led(led),
    .busy(busy)
  );

  task automatic drive(input logic r, input logic s, input logic p, input logic [1:0] m,
                       input logic [3:0] l, input logic [9:0] el, input logic eb);
    @(negedge clk);
    reset = r; start = s; stop = p; mode = m; level = l;
    sb.push_back('{el, eb});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      drive(k <= 2, k == 2, 1'b0, 2'b00, 4'd0, 10'h000, 1'b0);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL reset k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_solid();
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, k == 0, k == 20, k == 0 ? 2'b00 : 2'b10, k == 20 ? 4'd3 : 4'd9,
            (k >= 1 && k <= 20) ? 10'h3FF : (k >= 21 && k <= 28) ? 10'h007 : 10'h000,
            k >= 1 && k <= 28);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL solid k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_blink();
    for (int k = 0; k < 22; k++) begin
      drive(1'b0, k == 0, k == 12, k == 0 ? 2'b01 : 2'b00, 4'd0,
            (k >= 1 && k <= 12 && ((k - 1) / 4) % 2 == 0) ? 10'h3FF : 10'h000,
            k >= 1 && k <= 20);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL blink k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_chase_wrap();
    logic [9:0] el;
    for (int k = 0; k < 58; k++) begin
      el = 10'h000;
      if (k >= 1 && k <= 48) el = 10'h001 << (((k - 1) / 4) % 10);
      else if (k >= 49 && k <= 56) el = 10'h3FF;
      drive(1'b0, k == 0, k == 48, k == 0 ? 2'b10 : 2'b01, k == 48 ? 4'd15 : 4'd0, el,
            k >= 1 && k <= 56);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL chase k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, k == 0 || k == 3 || k == 5, k == 5, k == 3 ? 2'b01 : 2'b00, k == 5 ? 4'd2 : 4'd0,
            (k >= 1 && k <= 5) ? 10'h3FF : (k >= 6 && k <= 13) ? 10'h003 : 10'h000,
            k >= 1 && k <= 13);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL active_start_stop k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 0, k == 0, 2'b00, 4'd5, 10'h000, 1'b0);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL idle_start_stop k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_hold_restart();
    logic [9:0] el;
    for (int k = 0; k < 23; k++) begin
      el = (k >= 1 && k <= 3) ? 10'h3FF : (k == 4 || k == 5) ? 10'h00F :
           (k >= 6 && k <= 9) ? 10'h001 : (k >= 10 && k <= 13) ? 10'h002 : 10'h000;
      drive(1'b0, k == 0 || k == 5, k == 3 || k == 13, k == 5 ? 2'b10 : 2'b00, k == 3 ? 4'd4 : 4'd0,
            el, k >= 1 && k <= 21);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL hold_restart k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [9:0] el;
    logic eb;
    for (int k = 0; k < 18; k++) begin
      el = 10'h000;
      if (k >= 1 && k <= 4) el = 10'h001;
      else if (k == 5) el = 10'h002;
      else if (k >= 8 && k <= 10) el = 10'h3FF;
      else if (k == 11) el = 10'h01F;
      else if (k >= 14 && k <= 16) el = 10'h001;
      eb = (k >= 1 && k <= 5) || (k >= 8 && k <= 11) || (k >= 14 && k <= 16);
      drive(k == 6 || k == 12 || k == 17, k == 0 || k == 7 || k == 13, k == 10,
            (k == 0 || k == 13) ? 2'b10 : 2'b00, k == 10 ? 4'd5 : 4'd0, el, eb);
      e = sb.pop_front(); checks++;
      if ({led, busy} !== {e.led, e.busy}) begin
        errors++;
        $display("FAIL reset_midop k=%0d led=%h busy=%b want led=%h busy=%b", k, led, busy, e.led, e.busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_solid();
    test_blink();
    test_chase_wrap();
    test_simultaneous();
    test_hold_restart();
    test_reset_midop();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter LED_COUNT, default 10, number of LED outputs (legal range 2..32).
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clock cycles per animation tick (500 ms at 50 MHz; legal minimum 2).
REQ-003 SHALL have parameter HOLD_TICKS, default 4, ticks the result bar is shown after stop (0 = skip the hold).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, single-cycle pulse that begins the timing phase.
REQ-007 SHALL have port stop, input, 1 bit, single-cycle pulse that ends the timing phase.
REQ-008 SHALL have port mode, input, 2 bits, pattern for the timing phase: 00 solid, 01 blink, 10 chase, 11 reserved (treated as solid).
REQ-009 SHALL have port level, input, clog2(LED_COUNT+1) bits, result magnitude shown as a bar after stop.
REQ-010 SHALL have port led, output, LED_COUNT bits, registered LED drive with 1 = lit.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ACTIVE and HOLD.
REQ-013 IDLE SHALL drive led = all zeros.
REQ-014 IDLE + start SHALL go to ACTIVE, sample mode into a register, and clear the tick prescaler.
REQ-015 ACTIVE + stop SHALL sample level and go to HOLD if HOLD_TICKS>0, else to IDLE.
REQ-016 HOLD SHALL count HOLD_TICKS ticks, then go to IDLE; tick N returns to IDLE on the following cycle.
REQ-017 HOLD + start SHALL abandon the hold and re-enter ACTIVE as in REQ-014.
REQ-018 Start and stop in the same cycle SHALL give stop priority in ACTIVE and HOLD, and leave IDLE unchanged in IDLE.
REQ-019 start while ACTIVE SHALL be ignored; stop while IDLE SHALL be ignored.
REQ-020 led SHALL be registered: an event sampled at edge n is reflected on led after edge n+1 (one-cycle latency).
REQ-021 Tick SHALL be a one-cycle pulse every TICK_DIV cycles from a prescaler that runs only outside IDLE and restarts from 0 on entering ACTIVE or HOLD.
REQ-022 Solid mode SHALL drive led = all ones for the whole of ACTIVE.
REQ-023 Blink mode SHALL start with all ones and toggle between all ones and all zeros on every tick.
REQ-024 Chase mode SHALL start one-hot at bit 0 and rotate left by one on every tick, wrapping from bit LED_COUNT-1 to bit 0.
REQ-025 HOLD SHALL light the lowest min(level_latched, LED_COUNT) bits; a level above LED_COUNT saturates to all lit, and level 0 shows all off.
REQ-026 mode and level changes after sampling SHALL have no effect until the next sample.
REQ-027 busy SHALL be registered and aligned with the state (it rises with the first ACTIVE led value).

Reset
REQ-028 reset SHALL force state IDLE, led = 0, busy = 0, prescaler = 0, hold count = 0, and clear the latched mode, level and pattern registers.
REQ-029 reset SHALL take priority over start and stop in the same cycle and may be asserted in any state.
REQ-030 In the cycle after reset deasserts, the block SHALL accept start.

Structure
REQ-031 Package led_pkg SHALL hold the mode encodings (MODE_SOLID, MODE_BLINK, MODE_CHASE) and the state encodings (ST_IDLE, ST_ACTIVE, ST_HOLD).
REQ-032 Sub-module led_tick_gen SHALL contain the prescaler, with parameter TICK_DIV, inputs clk, reset, run and restart, and output tick.
REQ-033 The bar decode and pattern registers SHALL remain in led_sequencer.

Verification (LED_COUNT=10, TICK_DIV=4, HOLD_TICKS=2)
REQ-034 Solid path: start with mode 00, then stop after 20 cycles with level 3 -> led 0x3FF one cycle after start; 0x007 one cycle after stop for 8 cycles; then 0x000 and busy 0.
REQ-035 Blink: start with mode 01 -> led sequence 0x3FF, 0x000, 0x3FF, changing every 4 cycles.
REQ-036 Chase wrap: start with mode 10 and run 11 ticks -> led 0x001, 0x002, ... 0x200, 0x001, 0x002.
REQ-037 Edge cases: level 15 at stop -> 0x3FF in HOLD; start and stop together in ACTIVE -> HOLD entered; start and stop together in IDLE -> stays IDLE.
REQ-038 Reset mid-operation: reset in ACTIVE chase and in HOLD -> led 0x000 and busy 0 the next cycle; a start 1 cycle after reset releases -> normal ACTIVE.
